// File: rtl/ppu_pkg.sv
// Shared constants for the PPU timing/register front end: register selects,
// bit positions, NTSC default geometry and the status-flag bundle.
package ppu_pkg;

  localparam logic [2:0] RS_PPUCTRL   = 3'd0;
  localparam logic [2:0] RS_PPUMASK   = 3'd1;
  localparam logic [2:0] RS_PPUSTATUS = 3'd2;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int CTRL_NMI_EN   = 7;
  localparam int MASK_BG_EN    = 3;
  localparam int MASK_SPR_EN   = 4;
  localparam int STATUS_VBLANK = 7;
  localparam int STATUS_S0     = 6;
  localparam int STATUS_OVF    = 5;

  localparam int NTSC_H_TOTAL     = 341;
  localparam int NTSC_V_TOTAL     = 262;
  localparam int NTSC_H_VISIBLE   = 256;
  localparam int NTSC_V_VISIBLE   = 240;
  localparam int NTSC_VBLANK_LINE = 241;
  localparam int NTSC_CW          = 9;

  typedef struct packed {
    logic vblank;
    logic s0;
    logic ovf;
  } status_flags_t;

  // Flags occupy the top three bits; the rest echo the last value written to any register.
  function automatic logic [7:0] status_byte(input status_flags_t flags,
                                             input logic [4:0] latch);
    return {flags.vblank, flags.s0, flags.ovf, latch};
  endfunction

endpackage

// File: rtl/ppu_raster_counter.sv
// Dot/scanline position counters with the frame parity flag and the
// odd-frame short line used when rendering is enabled.
module ppu_raster_counter
  import ppu_pkg::*;
#(
  parameter int H_TOTAL  = NTSC_H_TOTAL,
  parameter int V_TOTAL  = NTSC_V_TOTAL,
  parameter int ODD_SKIP = 1,
  parameter int CW       = NTSC_CW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          rendering,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          frame_odd
);

  localparam logic [CW-1:0] X_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] X_SKIP = CW'(H_TOTAL - 2);
  localparam logic [CW-1:0] Y_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  logic line_end;
  logic frame_end;
  logic skip_dot;

  assign line_end  = (x == X_LAST);
  assign frame_end = line_end && (y == Y_LAST);
  // Odd frames drop the last dot of the pre-render line, jumping straight to (0,0).
  assign skip_dot  = (ODD_SKIP != 0) && frame_odd && rendering &&
                     (x == X_SKIP) && (y == Y_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x         <= '0;
      y         <= '0;
      frame_odd <= 1'b0;
    end else if (skip_dot) begin
      x         <= '0;
      y         <= '0;
      frame_odd <= ~frame_odd;
    end else if (line_end) begin
      x <= '0;
      if (frame_end) begin
        y         <= '0;
        frame_odd <= ~frame_odd;
      end else begin
        y <= y + ONE;
      end
    end else begin
      x <= x + ONE;
    end
  end

endmodule

// File: rtl/ppu_timing_ctrl.sv
// PPU raster timing plus the PPUCTRL/PPUMASK/PPUSTATUS register file,
// VBlank/NMI generation, sticky sprite flags and the CPU I/O latch.
module ppu_timing_ctrl
  import ppu_pkg::*;
#(
  parameter int H_TOTAL     = NTSC_H_TOTAL,
  parameter int V_TOTAL     = NTSC_V_TOTAL,
  parameter int H_VISIBLE   = NTSC_H_VISIBLE,
  parameter int V_VISIBLE   = NTSC_V_VISIBLE,
  parameter int VBLANK_LINE = NTSC_VBLANK_LINE,
  parameter int ODD_SKIP    = 1,
  parameter int CW          = NTSC_CW
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_cs_n,
  input  logic          i_rw,
  input  logic [2:0]    i_rs,
  input  logic [7:0]    i_data,
  output logic [7:0]    o_data,
  output logic          o_int_n,
  input  logic          i_sprite0_hit,
  input  logic          i_sprite_overflow,
  output logic [CW-1:0] o_video_x,
  output logic [CW-1:0] o_video_y,
  output logic          o_video_visible,
  output logic          o_rendering,
  output logic          o_frame_odd,
  output logic [7:0]    o_ppuctrl,
  output logic [7:0]    o_ppumask
);

  localparam logic [CW-1:0] FLAG_X     = CW'(1);
  localparam logic [CW-1:0] VBLANK_Y   = CW'(VBLANK_LINE);
  localparam logic [CW-1:0] PRERENDER_Y = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS      = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS      = CW'(V_VISIBLE);

  logic [7:0]    ctrl;
  logic [7:0]    mask;
  logic [4:0]    io_latch;
  status_flags_t flags;

  logic cpu_write;
  logic status_read;
  logic at_vblank_set;
  logic at_prerender_clear;

  ppu_raster_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .ODD_SKIP(ODD_SKIP),
    .CW      (CW)
  ) u_raster (
    .clk      (i_clk),
    .reset_n  (i_reset_n),
    .rendering(o_rendering),
    .x        (o_video_x),
    .y        (o_video_y),
    .frame_odd(o_frame_odd)
  );

  assign cpu_write   = !i_cs_n && (i_rw == RW_WRITE);
  assign status_read = !i_cs_n && (i_rw == RW_READ) && (i_rs == RS_PPUSTATUS);

  assign at_vblank_set      = (o_video_x == FLAG_X) && (o_video_y == VBLANK_Y);
  assign at_prerender_clear = (o_video_x == FLAG_X) && (o_video_y == PRERENDER_Y);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      ctrl     <= '0;
      mask     <= '0;
      io_latch <= '0;
      flags    <= '0;
    end else begin
      if (cpu_write) begin
        io_latch <= i_data[4:0];
        if (i_rs == RS_PPUCTRL) ctrl <= i_data;
        if (i_rs == RS_PPUMASK) mask <= i_data;
      end
      // Pre-render clear wins over sprite pulses; a status read on the set
      // dot wins over the set, so that frame never raises VBlank.
      if (at_prerender_clear) begin
        flags <= '0;
      end else begin
        if (i_sprite0_hit)     flags.s0  <= 1'b1;
        if (i_sprite_overflow) flags.ovf <= 1'b1;
        if (status_read)        flags.vblank <= 1'b0;
        else if (at_vblank_set) flags.vblank <= 1'b1;
      end
    end
  end

  always_comb begin
    o_data = '0;
    if (status_read) o_data = status_byte(flags, io_latch);
  end

  assign o_int_n         = !(flags.vblank && ctrl[CTRL_NMI_EN]);
  assign o_rendering     = mask[MASK_BG_EN] | mask[MASK_SPR_EN];
  assign o_video_visible = (o_video_x < H_VIS) && (o_video_y < V_VIS);
  assign o_ppuctrl       = ctrl;
  assign o_ppumask       = mask;

endmodule

// File: tb/tb_ppu_timing_ctrl.sv
// Bench for ppu_timing_ctrl on a reduced raster: directed scenarios with literal
// expectations, then random bus traffic against a frame-position reference model.
module tb_ppu_timing_ctrl;

  localparam int H     = 20;
  localparam int V     = 12;
  localparam int HV    = 16;
  localparam int VV    = 8;
  localparam int VBL   = 9;
  localparam int CW    = 9;
  localparam int FRAME = H * V;
  localparam int EW    = 2 * CW + 28;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       cs_n = 1'b1;
  logic       rw = 1'b1;
  logic [2:0] rs = 3'd0;
  logic [7:0] wdata = 8'h00;
  logic       s0_pulse = 1'b0;
  logic       ovf_pulse = 1'b0;

  logic [7:0]    data0, ctrl0, mask0, data1, ctrl1, mask1;
  logic          int_n0, vis0, rend0, odd0, int_n1, vis1, rend1, odd1;
  logic [CW-1:0] x0, y0, x1, y1;

  ppu_timing_ctrl #(
    .H_TOTAL(H), .V_TOTAL(V), .H_VISIBLE(HV), .V_VISIBLE(VV),
    .VBLANK_LINE(VBL), .ODD_SKIP(1), .CW(CW)
  ) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_cs_n(cs_n), .i_rw(rw), .i_rs(rs),
    .i_data(wdata), .o_data(data0), .o_int_n(int_n0),
    .i_sprite0_hit(s0_pulse), .i_sprite_overflow(ovf_pulse),
    .o_video_x(x0), .o_video_y(y0), .o_video_visible(vis0),
    .o_rendering(rend0), .o_frame_odd(odd0), .o_ppuctrl(ctrl0), .o_ppumask(mask0)
  );

  ppu_timing_ctrl #(
    .H_TOTAL(H), .V_TOTAL(V), .H_VISIBLE(HV), .V_VISIBLE(VV),
    .VBLANK_LINE(VBL), .ODD_SKIP(0), .CW(CW)
  ) dut_pal (
    .i_clk(clk), .i_reset_n(reset_n), .i_cs_n(cs_n), .i_rw(rw), .i_rs(rs),
    .i_data(wdata), .o_data(data1), .o_int_n(int_n1),
    .i_sprite0_hit(s0_pulse), .i_sprite_overflow(ovf_pulse),
    .o_video_x(x1), .o_video_y(y1), .o_video_visible(vis1),
    .o_rendering(rend1), .o_frame_odd(odd1), .o_ppuctrl(ctrl1), .o_ppumask(mask1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Position is a linear dot index within the frame; frame length is chosen per frame.
  int         m_pos = 0;
  bit         m_odd = 1'b0;
  bit         m_valid = 1'b0;
  logic [7:0] m_ctrl = 8'h00, m_mask = 8'h00;
  logic [4:0] m_latch = 5'h00;
  bit         m_vbl = 1'b0, m_s0 = 1'b0, m_ovf = 1'b0;

  int   m_x, m_y, m_flen;
  logic m_rd, m_wr, m_rend;

  always_comb begin
    m_x    = m_pos % H;
    m_y    = m_pos / H;
    m_rend = m_mask[3] | m_mask[4];
    m_flen = (m_odd && m_rend) ? FRAME - 1 : FRAME;
    m_rd   = !cs_n && rw && (rs == 3'd2);
    m_wr   = !cs_n && !rw;
  end

  function automatic logic [EW-1:0] model_out();
    logic [7:0] d;
    d = m_rd ? {m_vbl, m_s0, m_ovf, m_latch} : 8'h00;
    return {CW'(m_x), CW'(m_y), (m_x < HV) && (m_y < VV), m_rend, m_odd,
            !(m_vbl && m_ctrl[7]), d, m_ctrl, m_mask};
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_pos <= 0; m_odd <= 1'b0; m_ctrl <= 8'h00; m_mask <= 8'h00;
      m_latch <= 5'h00; m_vbl <= 1'b0; m_s0 <= 1'b0; m_ovf <= 1'b0;
      m_valid <= 1'b1;
    end else if (m_valid) begin
      if (s0_pulse)  m_s0 <= 1'b1;
      if (ovf_pulse) m_ovf <= 1'b1;
      if (m_rd) m_vbl <= 1'b0;
      else if (m_x == 1 && m_y == VBL) m_vbl <= 1'b1;
      if (m_x == 1 && m_y == V - 1) begin
        m_vbl <= 1'b0; m_s0 <= 1'b0; m_ovf <= 1'b0;
      end
      if (m_wr) begin
        m_latch <= wdata[4:0];
        if (rs == 3'd0) m_ctrl <= wdata;
        if (rs == 3'd1) m_mask <= wdata;
      end
      if (m_pos + 1 >= m_flen) begin
        m_pos <= 0;
        m_odd <= !m_odd;
      end else begin
        m_pos <= m_pos + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];

  always @(negedge clk) begin
    if (m_valid) begin
      exp_q.push_back(model_out());
      check("cycle", {x0, y0, vis0, rend0, odd0, int_n0, data0, ctrl0, mask0},
            exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    cs_n = 1'b1; rw = 1'b1; rs = 3'd0; wdata = 8'h00;
  endtask

  task automatic cpu_write(input logic [2:0] r, input logic [7:0] d);
    cs_n = 1'b0; rw = 1'b0; rs = r; wdata = d;
    tick();
    bus_idle();
  endtask

  task automatic cpu_read(input logic [2:0] r, output logic [7:0] d);
    cs_n = 1'b0; rw = 1'b1; rs = r;
    #1 d = data0;
    tick();
    bus_idle();
  endtask

  task automatic wait_pos(input int px, input int py);
    int n = 0;
    while (!(x0 == CW'(px) && y0 == CW'(py)) && n < 3 * FRAME) begin
      tick();
      n++;
    end
    if (!(x0 == CW'(px) && y0 == CW'(py))) begin
      checks++;
      errors++;
      $display("FAIL wait_pos timeout actual=(%0d,%0d) expected=(%0d,%0d)", x0, y0, px, py);
    end
  endtask

  task automatic measure(input int which, output int len);
    bit at_origin;
    len = 0;
    do begin
      tick();
      len++;
      at_origin = (which == 0) ? (x0 == '0 && y0 == '0) : (x1 == '0 && y1 == '0);
    end while (!at_origin && len < 2 * FRAME);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] d;
    int l, l1, l2, r;
    bit low_seen;

    bus_idle();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;

    cpu_write(3'd0, 8'h80);
    cpu_write(3'd1, 8'h18);
    repeat (37) tick();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    check("reset_x", x0, 0);
    check("reset_y", y0, 0);
    check("reset_int_n", int_n0, 1);
    check("reset_ctrl", ctrl0, 0);
    check("reset_mask", mask0, 0);
    check("reset_visible", vis0, 1);
    cpu_read(3'd2, d);
    check("reset_status", d, 0);

    measure(0, l);
    measure(0, l);
    check("frame_len_nomask_a", l, FRAME);
    measure(0, l);
    check("frame_len_nomask_b", l, FRAME);
    cpu_write(3'd1, 8'h18);
    measure(0, l);
    measure(0, l1);
    measure(0, l2);
    check("frame_len_alt_sum", l1 + l2, 2 * FRAME - 1);
    check("frame_len_alt_differ", l1 != l2, 1);
    measure(1, l);
    measure(1, l1);
    measure(1, l2);
    check("frame_len_noskip_a", l1, FRAME);
    check("frame_len_noskip_b", l2, FRAME);

    cpu_write(3'd0, 8'h5A);
    check("ctrl_write_latency", ctrl0, 8'h5A);

    cpu_write(3'd0, 8'h80);
    wait_pos(1, VBL);
    check("nmi_before_set", int_n0, 1);
    tick();
    check("nmi_assert", int_n0, 0);
    wait_pos(1, V - 1);
    check("nmi_hold_pre", int_n0, 0);
    tick();
    check("nmi_release", int_n0, 1);

    wait_pos(10, VBL);
    cpu_read(3'd2, d);
    check("status_vblank", d, 8'h80);
    check("nmi_ack", int_n0, 1);

    wait_pos(1, VBL);
    cpu_read(3'd2, d);
    check("race_status", d, 8'h00);
    low_seen = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      if (!int_n0) low_seen = 1'b1;
      if (x0 == '0 && y0 == '0) break;
      tick();
    end
    check("race_no_nmi", low_seen, 0);

    cpu_write(3'd0, 8'h00);
    wait_pos(5, VBL);
    check("late_before", int_n0, 1);
    cpu_write(3'd0, 8'h80);
    check("late_nmi", int_n0, 0);
    cpu_read(3'd2, d);
    check("late_ack", int_n0, 1);

    cpu_write(3'd0, 8'h00);
    wait_pos(5, 3);
    s0_pulse = 1'b1;
    tick();
    s0_pulse = 1'b0;
    wait_pos(10, 5);
    cpu_read(3'd2, d);
    check("s0_set", d[6], 1);
    wait_pos(1, V - 1);
    cpu_read(3'd2, d);
    check("s0_hold_pre", d[6], 1);
    cpu_read(3'd2, d);
    check("s0_cleared", d[6], 0);
    wait_pos(1, V - 1);
    s0_pulse = 1'b1;
    tick();
    s0_pulse = 1'b0;
    cpu_read(3'd2, d);
    check("s0_pre_priority", d[6], 0);
    wait_pos(3, 2);
    ovf_pulse = 1'b1;
    tick();
    ovf_pulse = 1'b0;
    cpu_read(3'd2, d);
    check("ovf_set", d[5], 1);

    cpu_write(3'd1, 8'h1F);
    cpu_read(3'd2, d);
    check("latch_low5", d[4:0], 5'h1F);
    cpu_read(3'd0, d);
    check("read_ctrl_zero", d, 0);
    cpu_read(3'd1, d);
    check("read_mask_zero", d, 0);

    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 20) begin
        cs_n  = 1'b0;
        rw    = 1'($urandom_range(0, 1));
        rs    = 3'($urandom_range(0, 7));
        wdata = 8'($urandom);
      end else begin
        bus_idle();
      end
      s0_pulse  = ($urandom_range(0, 15) == 0);
      ovf_pulse = ($urandom_range(0, 15) == 0);
      reset_n   = ($urandom_range(0, 799) != 0);
      tick();
    end
    bus_idle();
    s0_pulse = 1'b0;
    ovf_pulse = 1'b0;
    reset_n = 1'b1;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
